cpu_run_controller: RTL and testbench
=====================================

Name: cpu_run_controller

Overview:
Execution controller for the pipelined CPU on the VGA board. It consumes clean, one-pulsed button events produced by the button press units and sequences the CPU's clock enable in four modes: halted, free-run at a divided rate, fixed-length burst, and trapped. It also owns the VGA debug page selector. It sits between the button front-end and the CPU/VGA datapath.

Parameters:
RATE_WIDTH, 18, width of the run-rate counter; in RUN, one cpu_en pulse every 2^RATE_WIDTH cycles
BURST, 16, number of consecutive cpu_en cycles per burst command; must be ≥1 and ≤65535
PAGE_COUNT, 4, number of VGA debug pages; must be ≥1 and ≤4

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset; 0 = reset asserted
btn_run  input  1  one-cycle pulse; toggles run/halt, and aborts a burst
btn_burst  input  1  one-cycle pulse; starts a burst of BURST enables
btn_step  input  1  one-cycle pulse; issues a single cpu_en while halted
btn_page  input  1  one-cycle pulse; advances the VGA page
halt_req  input  1  level signal from the CPU (trap/syscall halt); sampled every cycle
cpu_en  output  1  registered CPU clock enable; one cycle per CPU step
state  output  2  current mode: 0 HALT, 1 RUN, 2 BURST, 3 TRAP
page  output  2  current VGA page, 0..PAGE_COUNT-1
step_count  output  16  number of cycles with cpu_en=1 since reset; wraps at 16 bits

Behaviour:
- Reset (reset=0, asynchronous): state=HALT, cpu_en=0, page=0, step_count=0, rate counter=0, burst counter=0.
- All outputs are registered. A button pulse sampled at edge t takes effect from cycle t+1.
- Priority for events sampled in the same cycle: halt_req > btn_run > btn_burst > btn_step. Lower-priority events are dropped, not queued.
- halt_req=1 in any state, including TRAP:
  - next state=TRAP and cpu_en=0 in the next cycle, even if other buttons pulse in the same cycle.
  - TRAP exits only via reset; every button except btn_page is ignored in TRAP.
- HALT:
  - btn_run -> RUN; the rate counter is cleared to 0.
  - btn_burst -> BURST; burst counter loaded with BURST.
  - btn_step -> cpu_en=1 for exactly one cycle; state stays HALT.
  - Otherwise cpu_en=0.
- RUN:
  - Rate counter increments every cycle and wraps at 2^RATE_WIDTH.
  - cpu_en=1 in the cycle after the counter holds all-ones. The first pulse occurs 2^RATE_WIDTH cycles after RUN entry; the period is 2^RATE_WIDTH thereafter.
  - btn_run -> HALT, with cpu_en=0 in the next cycle.
  - btn_burst and btn_step are ignored.
- BURST:
  - cpu_en=1 in every BURST cycle; the burst counter decrements once per cycle.
  - The cycle in which the counter goes from 1 to 0 is the last enable; the next state is HALT.
  - Result: btn_burst at edge t gives cpu_en=1 at cycles t+1..t+BURST and state=HALT at t+BURST+1.
  - btn_run aborts the burst -> HALT, with cpu_en=0 in the next cycle.
  - btn_burst and btn_step are ignored.
- page:
  - On btn_page, page = (page+1) mod PAGE_COUNT, in every state including TRAP.
  - Independent of the priority chain, so it may coincide with any other event.
- step_count increments by 1 on every edge where cpu_en=1, and wraps 0xFFFF -> 0x0000.
- The state encoding is fixed as listed under Ports; the value 3 (TRAP) is reachable only via halt_req.

Decomposition:
- Shared package:
  - state encoding constants: ST_HALT=2'd0, ST_RUN=2'd1, ST_BURST=2'd2, ST_TRAP=2'd3.
  - STEP_COUNT_W=16.
- One sub-module: rate_tick.
  - A RATE_WIDTH-bit free counter with asynchronous active-low reset, a synchronous clear, and an enable.
  - Outputs a one-cycle tick when the count is all-ones.
  - Instantiated once, for the RUN rate.

Test Plan:
Use RATE_WIDTH=3, BURST=4, PAGE_COUNT=3 for all scenarios.
1. Reset, then btn_step at cycles 10 and 20 -> cpu_en=1 at cycles 11 and 21 only; state=0 throughout; step_count=2.
2. btn_run at cycle 5, then btn_run at cycle 30 -> state=1 from cycle 6; cpu_en=1 at cycles 14, 22 and 30; state=0 and cpu_en=0 from cycle 31; step_count=3.
3. btn_burst at cycle 5 -> cpu_en=1 at cycles 6-9, state=2 at cycles 6-9, state=0 at cycle 10; step_count=4. A btn_step at cycle 7 has no extra effect.
4. btn_burst at 5, then halt_req=1 at 7 together with btn_run -> state=3 and cpu_en=0 from cycle 8. Later btn_run, btn_burst and btn_step pulses are ignored. btn_page still moves page to 1. Asserting reset=0 mid-trap clears state, page and step_count to 0 immediately.
5. Four btn_page pulses, one coinciding with btn_run -> page sequence 1, 2, 0, 1; the RUN entry still occurs.
6. Simultaneous btn_burst and btn_step while HALT -> BURST is entered, giving exactly 4 enables and no extra single step.

Source files
------------

// File: rtl/cpu_run_controller_pkg.sv
// Shared definitions for the CPU run controller.
// Contents: mode encoding (as seen on the state output), step counter width and
// burst counter width.

package cpu_run_controller_pkg;

  // The encoding is visible on the state output, so the values are fixed.
  typedef enum logic [1:0] {
    ST_HALT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_BURST = 2'd2,
    ST_TRAP  = 2'd3
  } run_state_e;

  localparam int unsigned STEP_COUNT_W = 16;
  localparam int unsigned BURST_CNT_W  = 16;

endpackage

// File: rtl/cpu_run_controller_rate_tick.sv
// Free-running rate counter that produces the RUN-mode step tick.
// Ports:
//   i_clk    - system clock
//   i_rst_n  - asynchronous active-low reset, clears the count
//   i_clr    - synchronous clear to 0, wins over i_en
//   i_en     - count enable
//   o_tick   - high while enabled and the count is all-ones

module cpu_run_controller_rate_tick
  import cpu_run_controller_pkg::*;
#(
  parameter int unsigned RATE_WIDTH = 18
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tick
);

  logic [RATE_WIDTH-1:0] r_count;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count + RATE_WIDTH'(1);
    end
  end

  // Gated with the enable so a count parked at all-ones while idle never ticks.
  assign o_tick = i_en && (r_count == '1);

endmodule

// File: rtl/cpu_run_controller.sv
// Execution controller for the pipelined CPU: sequences the CPU clock enable in
// HALT / RUN / BURST / TRAP modes from one-pulsed button events, and owns the VGA
// debug page selector.
// Ports:
//   clk        - system clock
//   reset      - asynchronous active-low reset
//   btn_run    - pulse: toggle run/halt, abort a burst
//   btn_burst  - pulse: start a burst of BURST enables (from HALT)
//   btn_step   - pulse: single enable (from HALT)
//   btn_page   - pulse: advance VGA page, works in every mode
//   halt_req   - level from CPU: forces TRAP, left only by reset
//   cpu_en     - registered CPU clock enable
//   state      - current mode (0 HALT, 1 RUN, 2 BURST, 3 TRAP)
//   page       - current VGA page, 0..PAGE_COUNT-1
//   step_count - count of cpu_en cycles since reset, wrapping

module cpu_run_controller
  import cpu_run_controller_pkg::*;
#(
  parameter int unsigned RATE_WIDTH = 18,
  parameter int unsigned BURST      = 16,
  parameter int unsigned PAGE_COUNT = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    btn_run,
  input  logic                    btn_burst,
  input  logic                    btn_step,
  input  logic                    btn_page,
  input  logic                    halt_req,
  output logic                    cpu_en,
  output logic [1:0]              state,
  output logic [1:0]              page,
  output logic [STEP_COUNT_W-1:0] step_count
);

  localparam logic [1:0]             PageLast  = 2'(PAGE_COUNT - 1);
  localparam logic [BURST_CNT_W-1:0] BurstLoad = BURST_CNT_W'(BURST);

  run_state_e              r_state, w_state_d;
  logic                    r_cpu_en, w_cpu_en_d;
  logic [BURST_CNT_W-1:0]  r_burst, w_burst_d;
  logic [1:0]              r_page, w_page_d;
  logic [STEP_COUNT_W-1:0] r_steps;
  logic                    w_rate_clr;
  logic                    w_rate_en;
  logic                    w_rate_tick;

  assign w_rate_en = (r_state == ST_RUN);

  cpu_run_controller_rate_tick #(
    .RATE_WIDTH(RATE_WIDTH)
  ) u_rate_tick (
    .i_clk  (clk),
    .i_rst_n(reset),
    .i_clr  (w_rate_clr),
    .i_en   (w_rate_en),
    .o_tick (w_rate_tick)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= ST_HALT;
      r_cpu_en <= 1'b0;
      r_burst  <= '0;
      r_page   <= 2'd0;
      r_steps  <= '0;
    end else begin
      r_state  <= w_state_d;
      r_cpu_en <= w_cpu_en_d;
      r_burst  <= w_burst_d;
      r_page   <= w_page_d;
      if (r_cpu_en) begin
        r_steps <= r_steps + STEP_COUNT_W'(1);
      end
    end
  end

  // Priority: halt_req > btn_run > btn_burst > btn_step; losers are dropped.
  always_comb begin
    w_state_d  = r_state;
    w_cpu_en_d = 1'b0;
    w_burst_d  = r_burst;
    w_rate_clr = 1'b0;
    if (halt_req) begin
      w_state_d = ST_TRAP;
    end else begin
      unique case (r_state)
        ST_HALT: begin
          if (btn_run) begin
            w_state_d  = ST_RUN;
            w_rate_clr = 1'b1;
          end else if (btn_burst) begin
            w_state_d  = ST_BURST;
            w_burst_d  = BurstLoad;
            w_cpu_en_d = 1'b1;
          end else if (btn_step) begin
            w_cpu_en_d = 1'b1;
          end
        end
        ST_RUN: begin
          if (btn_run) begin
            w_state_d = ST_HALT;
          end else begin
            w_cpu_en_d = w_rate_tick;
          end
        end
        ST_BURST: begin
          if (btn_run) begin
            w_state_d = ST_HALT;
          end else begin
            w_burst_d = r_burst - BURST_CNT_W'(1);
            // Counter at 1 marks the last enabled cycle of the burst.
            if (r_burst == BURST_CNT_W'(1)) begin
              w_state_d = ST_HALT;
            end else begin
              w_cpu_en_d = 1'b1;
            end
          end
        end
        ST_TRAP: begin
          w_state_d = ST_TRAP;
        end
        default: begin
          w_state_d = ST_HALT;
        end
      endcase
    end
  end

  always_comb begin
    w_page_d = r_page;
    if (btn_page) begin
      w_page_d = (r_page == PageLast) ? 2'd0 : r_page + 2'd1;
    end
  end

  assign cpu_en     = r_cpu_en;
  assign state      = r_state;
  assign page       = r_page;
  assign step_count = r_steps;

endmodule

// File: tb/tb_cpu_run_controller.sv
module tb_cpu_run_controller;

  localparam int unsigned RateWidth  = 3;
  localparam int unsigned Burst      = 4;
  localparam int unsigned PageCount  = 3;
  localparam int          RatePeriod = 8;

  logic        clk;
  logic        reset;
  logic        btn_run;
  logic        btn_burst;
  logic        btn_step;
  logic        btn_page;
  logic        halt_req;
  logic        cpu_en;
  logic [1:0]  state;
  logic [1:0]  page;
  logic [15:0] step_count;

  cpu_run_controller #(
    .RATE_WIDTH(RateWidth),
    .BURST     (Burst),
    .PAGE_COUNT(PageCount)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .btn_run   (btn_run),
    .btn_burst (btn_burst),
    .btn_step  (btn_step),
    .btn_page  (btn_page),
    .halt_req  (halt_req),
    .cpu_en    (cpu_en),
    .state     (state),
    .page      (page),
    .step_count(step_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  st;
    logic        en;
    logic [1:0]  pg;
    logic [15:0] cnt;
  } exp_t;

  exp_t exp_q[$];

  int n_checks;
  int n_errors;

  // Reference model state: mode, outputs, and schedule markers.
  int          m_cyc;
  logic [1:0]  m_st;
  logic        m_en;
  logic [1:0]  m_pg;
  logic [15:0] m_cnt;
  int          m_run_entry;
  int          m_burst_end;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    btn_run = 1'b0;
    btn_burst = 1'b0;
    btn_step = 1'b0;
    btn_page = 1'b0;
    halt_req = 1'b0;
    exp_q.delete();
    m_cyc = 0;
    m_st = 2'd0;
    m_en = 1'b0;
    m_pg = 2'd0;
    m_cnt = 16'd0;
    m_run_entry = 0;
    m_burst_end = 0;
    @(negedge clk);
    @(negedge clk);
    check_eq("rst_state", int'(state), 0);
    check_eq("rst_cpu_en", int'(cpu_en), 0);
    check_eq("rst_page", int'(page), 0);
    check_eq("rst_steps", int'(step_count), 0);
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Drives one cycle of inputs, pushes the model's expectation for the next
  // cycle, then pops and compares once the DUT has produced it.
  task automatic run_cycle(input logic run, input logic burst, input logic step,
                           input logic pg, input logic halt);
    exp_t e;
    exp_t got;
    btn_run = run;
    btn_burst = burst;
    btn_step = step;
    btn_page = pg;
    halt_req = halt;

    e.cnt = m_en ? m_cnt + 16'd1 : m_cnt;
    e.pg  = pg ? 2'((int'(m_pg) + 1) % PageCount) : m_pg;
    e.st  = m_st;
    e.en  = 1'b0;
    if (halt) begin
      e.st = 2'd3;
    end else begin
      case (m_st)
        2'd0: begin
          if (run) begin
            e.st = 2'd1;
            m_run_entry = m_cyc + 1;
          end else if (burst) begin
            e.st = 2'd2;
            m_burst_end = m_cyc + Burst;
            e.en = 1'b1;
          end else if (step) begin
            e.en = 1'b1;
          end
        end
        2'd1: begin
          if (run) e.st = 2'd0;
          else e.en = ((m_cyc + 1 - m_run_entry) % RatePeriod) == 0;
        end
        2'd2: begin
          if (run) e.st = 2'd0;
          else if (m_cyc + 1 > m_burst_end) e.st = 2'd0;
          else e.en = 1'b1;
        end
        default: ;
      endcase
    end
    exp_q.push_back(e);
    m_st = e.st;
    m_en = e.en;
    m_pg = e.pg;
    m_cnt = e.cnt;
    m_cyc++;

    @(posedge clk);
    #1;
    btn_run = 1'b0;
    btn_burst = 1'b0;
    btn_step = 1'b0;
    btn_page = 1'b0;
    halt_req = 1'b0;
    if (exp_q.size() == 0) begin
      check_eq("sb_empty", 1, 0);
    end else begin
      got = exp_q.pop_front();
      check_eq("state", int'(state), int'(got.st));
      check_eq("cpu_en", int'(cpu_en), int'(got.en));
      check_eq("page", int'(page), int'(got.pg));
      check_eq("step_count", int'(step_count), int'(got.cnt));
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;

    // 1: single steps while halted.
    do_reset();
    for (int c = 0; c < 25; c++) run_cycle(1'b0, 1'b0, (c == 10) || (c == 20), 1'b0, 1'b0);
    check_eq("s1_steps", int'(step_count), 2);
    check_eq("s1_state", int'(state), 0);

    // 2: run then halt; pulses at 14, 22, 30.
    do_reset();
    for (int c = 0; c < 35; c++) run_cycle((c == 5) || (c == 30), 1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("s2_steps", int'(step_count), 3);
    check_eq("s2_state", int'(state), 0);

    // 3: burst with a stray step inside it.
    do_reset();
    for (int c = 0; c < 15; c++) run_cycle(1'b0, c == 5, c == 7, 1'b0, 1'b0);
    check_eq("s3_steps", int'(step_count), 4);
    check_eq("s3_state", int'(state), 0);

    // 4: trap during a burst, buttons ignored, page still moves, async reset.
    do_reset();
    for (int c = 0; c < 20; c++) begin
      run_cycle((c == 7) || (c == 12), (c == 5) || (c == 14), c == 16, c == 10, c == 7);
    end
    check_eq("s4_state", int'(state), 3);
    check_eq("s4_page", int'(page), 1);
    check_eq("s4_steps", int'(step_count), 2);
    reset = 1'b0;
    #2;
    check_eq("s4_async_state", int'(state), 0);
    check_eq("s4_async_page", int'(page), 0);
    check_eq("s4_async_steps", int'(step_count), 0);

    // 5: page wrap, one page pulse coinciding with run.
    do_reset();
    for (int c = 0; c < 20; c++) begin
      run_cycle(c == 6, 1'b0, 1'b0, (c == 2) || (c == 4) || (c == 6) || (c == 8), 1'b0);
    end
    check_eq("s5_page", int'(page), 1);
    check_eq("s5_state", int'(state), 1);

    // 6: burst and step together from HALT.
    do_reset();
    for (int c = 0; c < 13; c++) run_cycle(1'b0, c == 3, c == 3, 1'b0, 1'b0);
    check_eq("s6_steps", int'(step_count), 4);
    check_eq("s6_state", int'(state), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
